// File: rtl/tdes_ahb_ctrl.sv
// AHB-Lite slave front end for a 3DES core: mode/key/chunk registers, core handshake, result FIFO.
// Single-cycle data phase when nothing stalls; illegal accesses take the two-cycle ERROR response.
// HREADY is pulled low while the core, in-flight count or FIFO is not ready; stalls time out into ERROR.
module tdes_ahb_ctrl #(
  parameter int DATA_W    = 64,
  parameter int OUT_DEPTH = 4,
  parameter int WAIT_MAX  = 64
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADY,
  output logic              HRESP,
  output logic              core_mode,
  output logic [DATA_W-1:0] core_key1,
  output logic [DATA_W-1:0] core_key2,
  output logic [DATA_W-1:0] core_key3,
  output logic [DATA_W-1:0] core_data,
  output logic              core_valid,
  input  logic              core_ready,
  input  logic [DATA_W-1:0] core_result,
  input  logic              core_result_valid,
  output logic              core_result_ready
);

  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_ADDR,
    S_DATA,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  typedef enum logic [2:0] {
    R_MODE,
    R_KEY1,
    R_KEY2,
    R_KEY3,
    R_CHUNK
  } reg_t;

  state_t state, state_nx;

  // Address-phase decode results and their captured copies for the data phase
  reg_t dec_sel;
  logic dec_ok;
  reg_t sel_q;
  logic wr_q;

  // Stall / completion qualifiers for the current data phase
  logic in_data;
  logic stall;
  logic done;
  logic expire;
  logic ready_now;
  logic accept;

  logic [WCNT_W-1:0] wcnt;
  logic [3:0]        inflight;

  // Result FIFO storage
  logic [DATA_W-1:0] fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  logic              hs_in;
  logic              hs_out;
  logic [3:0]        cnt4;
  logic [DATA_W-1:0] status_word;

  // BUSY (HTRANS=01) is treated like IDLE, so only bit 1 matters
  logic unused_htrans;
  assign unused_htrans = HTRANS[0];

  // Decode the address phase: which register, and whether the access is legal
  always_comb begin
    dec_sel = R_MODE;
    dec_ok  = 1'b0;
    case (HADDR)
      32'h0000_0000: begin dec_sel = R_MODE;  dec_ok = 1'b1;   end
      32'h0000_0400: begin dec_sel = R_KEY1;  dec_ok = HWRITE; end
      32'h0000_0800: begin dec_sel = R_KEY2;  dec_ok = HWRITE; end
      32'h0000_0C00: begin dec_sel = R_KEY3;  dec_ok = HWRITE; end
      32'h0000_1000: begin dec_sel = R_CHUNK; dec_ok = 1'b1;   end
      default: ;
    endcase
    if (HSIZE != 3'b011) dec_ok = 1'b0;
  end

  assign fifo_full  = (fifo_count == CNT_W'(OUT_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  // Data-phase stall: pending chunk not yet taken, key/mode change under in-flight work, or empty FIFO read
  always_comb begin
    in_data = (state == S_DATA) || (state == S_WAIT);
    stall   = 1'b0;
    if (in_data) begin
      if (wr_q && sel_q == R_CHUNK)      stall = core_valid && !core_ready;
      else if (wr_q)                     stall = (inflight != 4'd0);
      else if (sel_q == R_MODE)          stall = fifo_empty;
    end
  end

  assign done      = in_data && !stall;
  assign expire    = (state == S_WAIT) && stall && (wcnt == WCNT_W'(WAIT_MAX - 1));
  assign ready_now = !(stall || state == S_ERR1);
  // Address phases during the second ERROR cycle are dropped even though HREADY is high
  assign accept    = HTRANS[1] && ready_now && (state != S_ERR2);

  assign HREADY = ready_now;
  assign HRESP  = (state == S_ERR1) || (state == S_ERR2);

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= S_ADDR;
    else        state <= state_nx;
  end

  // Next-state: pipelined accept on the completing cycle, stall into WAIT, timeout into ERROR
  always_comb begin
    state_nx = state;
    case (state)
      S_ADDR: begin
        if (accept) state_nx = dec_ok ? S_DATA : S_ERR1;
      end
      S_DATA, S_WAIT: begin
        if (stall)       state_nx = expire ? S_ERR1 : S_WAIT;
        else if (accept) state_nx = dec_ok ? S_DATA : S_ERR1;
        else             state_nx = S_ADDR;
      end
      S_ERR1:  state_nx = S_ERR2;
      S_ERR2:  state_nx = S_ADDR;
      default: state_nx = S_ADDR;
    endcase
  end

  // Capture the accepted address phase for use in its data phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_q <= R_MODE;
      wr_q  <= 1'b0;
    end else if (accept) begin
      sel_q <= dec_sel;
      wr_q  <= HWRITE;
    end
  end

  // Count consecutive stalled WAIT cycles; cleared whenever not stalling in WAIT
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                         wcnt <= '0;
    else if (state == S_WAIT && stall)  wcnt <= wcnt + WCNT_W'(1);
    else                                wcnt <= '0;
  end

  // Mode and key registers, written only on a completing data phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      core_mode <= 1'b0;
      core_key1 <= '0;
      core_key2 <= '0;
      core_key3 <= '0;
    end else if (done && wr_q) begin
      case (sel_q)
        R_MODE:  core_mode <= HWDATA[0];
        R_KEY1:  core_key1 <= HWDATA;
        R_KEY2:  core_key2 <= HWDATA;
        R_KEY3:  core_key3 <= HWDATA;
        default: ;
      endcase
    end
  end

  assign hs_in  = core_valid && core_ready;
  assign hs_out = core_result_valid && core_result_ready;

  // Chunk register: held until the core takes it; a new load in the handshake cycle keeps valid high
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      core_data  <= '0;
      core_valid <= 1'b0;
    end else begin
      if (hs_in) core_valid <= 1'b0;
      if (done && wr_q && sel_q == R_CHUNK) begin
        core_data  <= HWDATA;
        core_valid <= 1'b1;
      end
    end
  end

  // Chunks handed to the core but whose results have not yet been accepted
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) inflight <= 4'd0;
    else begin
      case ({hs_in, hs_out})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: ;
      endcase
    end
  end

  // A full FIFO still accepts a result in the cycle it is being popped
  assign pop               = done && !wr_q && (sel_q == R_MODE);
  assign core_result_ready = !fifo_full || pop;
  assign push              = hs_out;

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage has no reset; contents are only visible behind the occupancy count
  always_ff @(posedge HCLK) begin
    if (push) fifo_mem[wptr] <= core_result;
  end

  assign cnt4 = 4'(fifo_count);

  // Read data only on the completing cycle of a read; zero at all other times
  always_comb begin
    status_word      = '0;
    status_word[8:0] = {cnt4, inflight, core_valid};
    HRDATA           = '0;
    if (done && !wr_q) begin
      if (sel_q == R_MODE)       HRDATA = fifo_mem[rptr];
      else if (sel_q == R_CHUNK) HRDATA = status_word;
    end
  end

endmodule
